// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: small in-order store buffer between a core's data-memory
// write port and a valid/ready memory bus. Stores are queued in a circular
// buffer; a store to the same word as the newest non-head entry is merged
// into that entry byte-by-byte instead of consuming a new slot.
//
// Bus handshake: bus_valid is high whenever the buffer holds at least one
// entry and presents the head entry on bus_addr/bus_wdata/bus_wstrb; the
// entry is consumed on a rising clock edge where bus_valid and bus_ready are
// both high. While bus_valid is high and bus_ready is low the head entry and
// therefore the bus outputs stay unchanged. bus_ready is ignored when empty.
// Core side: a store is requested by any nonzero io_dmem_wen; io_stall tells
// the core that the buffer is full and the store was not taken this cycle.
module dmem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [AW-1:0]            io_dmem_waddr,
    input  logic [DW-1:0]            io_dmem_wdata,
    input  logic [DW/8-1:0]          io_dmem_wen,
    output logic                     io_stall,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [AW-1:0]            bus_addr,
    output logic [DW-1:0]            bus_wdata,
    output logic [DW/8-1:0]          bus_wstrb,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = DW / 8;

    // Entry storage; contents are only meaningful for occupied slots, so it
    // carries no reset.
    logic [AW-1:0] entry_addr_q [DEPTH];
    logic [DW-1:0] entry_data_q [DEPTH];
    logic [SW-1:0] entry_strb_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          store_req;
    logic          full;
    logic          accept;
    logic          merge_hit;
    logic          enq;
    logic          deq;
    logic [PW-1:0] tail_last;

    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;

    // Classify this cycle's store: stall, merge into the newest entry, or enqueue.
    always_comb begin
        store_req = |io_dmem_wen;
        full      = (count_q == CW'(DEPTH));
        accept    = store_req && !full;
        tail_last = tail_q - PW'(1);
        // With two or more entries the newest one is never the head, so a
        // merge cannot disturb the entry currently shown on the bus.
        merge_hit = accept && (count_q >= CW'(2)) &&
                    (entry_addr_q[tail_last][AW-1:2] == io_dmem_waddr[AW-1:2]);
        enq       = accept && !merge_hit;
        deq       = (count_q != '0) && bus_ready;
        io_stall  = store_req && full;
    end

    // Build the entry write: fresh entry at the tail, or lane-wise merge into tail-1.
    always_comb begin
        wr_en   = accept;
        wr_idx  = merge_hit ? tail_last : tail_q;
        wr_addr = io_dmem_waddr & ~AW'(3);
        wr_data = '0;
        for (int i = 0; i < SW; i++) begin
            if (merge_hit && !io_dmem_wen[i]) begin
                wr_data[8*i +: 8] = entry_data_q[tail_last][8*i +: 8];
            end else begin
                wr_data[8*i +: 8] = io_dmem_wdata[8*i +: 8];
            end
        end
        wr_strb = merge_hit ? (entry_strb_q[tail_last] | io_dmem_wen) : io_dmem_wen;
    end

    // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q + PW'(deq);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q + CW'(enq) - CW'(deq);
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            entry_addr_q[wr_idx] <= wr_addr;
            entry_data_q[wr_idx] <= wr_data;
            entry_strb_q[wr_idx] <= wr_strb;
        end
    end

    // Present the head entry; drive zeros when empty so reset clears the bus at once.
    always_comb begin
        bus_valid = (count_q != '0);
        count     = count_q;
        if (bus_valid) begin
            bus_addr  = entry_addr_q[head_q];
            bus_wdata = entry_data_q[head_q];
            bus_wstrb = entry_strb_q[head_q];
        end else begin
            bus_addr  = '0;
            bus_wdata = '0;
            bus_wstrb = '0;
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: directed scenarios followed by random traffic,
// all checked each cycle against a queue-based model of the buffer.
module tb_dmem_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;

    logic          clock;
    logic          reset;
    logic [AW-1:0] io_dmem_waddr;
    logic [DW-1:0] io_dmem_wdata;
    logic [SW-1:0] io_dmem_wen;
    logic          io_stall;
    logic          bus_valid;
    logic          bus_ready;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [SW-1:0] bus_wstrb;
    logic [2:0]    count;

    dmem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_dmem_waddr (io_dmem_waddr),
        .io_dmem_wdata (io_dmem_wdata),
        .io_dmem_wen   (io_dmem_wen),
        .io_stall      (io_stall),
        .bus_valid     (bus_valid),
        .bus_ready     (bus_ready),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .count         (count)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the buffer is simply an ordered list of pending writes.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } ent_t;

    ent_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the inputs currently driven.
    task automatic check_outputs(input string tag);
        ent_t h;
        h = '0;
        if (exp_q.size() != 0) h = exp_q[0];
        chk({tag, "_stall"}, 32'(io_stall), 32'((exp_q.size() == DEPTH) && (io_dmem_wen != '0)));
        chk({tag, "_valid"}, 32'(bus_valid), 32'(exp_q.size() != 0));
        chk({tag, "_addr"},  bus_addr, h.a);
        chk({tag, "_wdata"}, bus_wdata, h.d);
        chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'(h.s));
        chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    endtask

    // Model of one clock edge: accept (merge or append), then retire the oldest.
    task automatic model_edge();
        bit   acc;
        bit   pop;
        ent_t e;
        acc = (io_dmem_wen != '0) && (exp_q.size() < DEPTH);
        pop = (exp_q.size() != 0) && bus_ready;
        if (acc) begin
            if (exp_q.size() >= 2 && exp_q[exp_q.size()-1].a[AW-1:2] == io_dmem_waddr[AW-1:2]) begin
                e = exp_q[exp_q.size()-1];
                for (int i = 0; i < SW; i++)
                    if (io_dmem_wen[i]) e.d[8*i +: 8] = io_dmem_wdata[8*i +: 8];
                e.s = e.s | io_dmem_wen;
                exp_q[exp_q.size()-1] = e;
            end else begin
                e.a = {io_dmem_waddr[AW-1:2], 2'b00};
                e.d = io_dmem_wdata;
                e.s = io_dmem_wen;
                exp_q.push_back(e);
            end
        end
        if (pop) void'(exp_q.pop_front());
    endtask

    // Driver: one full cycle with the given inputs, checked before the edge.
    task automatic cycle(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] w, input logic r);
        io_dmem_waddr = a;
        io_dmem_wdata = d;
        io_dmem_wen   = w;
        bus_ready     = r;
        #1;
        check_outputs(tag);
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input string tag, input logic r);
        cycle(tag, '0, '0, '0, r);
    endtask

    logic [AW-1:0] fill_addr [4];
    int guard;

    initial begin
        reset         = 1'b1;
        io_dmem_waddr = '0;
        io_dmem_wdata = '0;
        io_dmem_wen   = '0;
        bus_ready     = 1'b0;
        fill_addr[0] = 32'h0;  fill_addr[1] = 32'h10;
        fill_addr[2] = 32'h20; fill_addr[3] = 32'h30;

        // Reset state
        @(posedge clock);
        #2;
        check_outputs("rst");
        chk("rst_count0", 32'(count), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single store goes out the cycle after acceptance
        cycle("s1", 32'h1004, 32'hDEADBEEF, 4'hF, 1'b1);
        chk("s1_addr_lit", bus_addr, 32'h1004);
        chk("s1_strb_lit", 32'(bus_wstrb), 32'hF);
        chk("s1_valid_lit", 32'(bus_valid), 32'd1);
        idle("s1_drain", 1'b1);
        chk("s1_empty", 32'(count), 32'd0);

        // Fill to full, stall the fifth store, then drain in order
        for (int i = 0; i < 4; i++) cycle("fill", fill_addr[i], 32'h100 + i, 4'hF, 1'b0);
        chk("fill_count4", 32'(count), 32'd4);
        cycle("fill_stall", 32'h40, 32'h55, 4'hF, 1'b0);
        chk("fill_still4", 32'(count), 32'd4);
        io_dmem_wen = 4'hF;
        #1;
        chk("fill_stall_lit", 32'(io_stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", bus_addr, fill_addr[i]);
            idle("drain", 1'b1);
        end
        chk("drain_empty", 32'(count), 32'd0);

        // Merge into the newest non-head entry
        cycle("m1", 32'h100, 32'h000000AA, 4'h1, 1'b0);
        cycle("m2", 32'h200, 32'h00001234, 4'h3, 1'b0);
        cycle("m3", 32'h202, 32'hBBBB0000, 4'hC, 1'b0);
        chk("m_count2", 32'(count), 32'd2);
        idle("m_pop", 1'b1);
        chk("m_addr", bus_addr, 32'h200);
        chk("m_strb", 32'(bus_wstrb), 32'hF);
        chk("m_hi", 32'(bus_wdata[31:16]), 32'hBBBB);
        idle("m_drain", 1'b1);

        // Same word as a lone head entry must not merge
        cycle("h1", 32'h300, 32'h11111111, 4'hF, 1'b0);
        cycle("h2", 32'h300, 32'h22222222, 4'hF, 1'b0);
        chk("h_count2", 32'(count), 32'd2);
        chk("h_head_data", bus_wdata, 32'h11111111);
        idle("h_d1", 1'b1);
        idle("h_d2", 1'b1);

        // Back-to-back stores with toggling ready, across pointer wrap
        for (int i = 0; i < 10; i++)
            cycle("wrap", 32'h400 + 32'(16 * i), $urandom, 4'hF, 1'(i % 2));
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            idle("wrap_drain", 1'b1);
            guard++;
        end
        chk("wrap_empty", 32'(count), 32'd0);

        // Reset between clock edges discards in-flight entries immediately
        for (int i = 0; i < 3; i++) cycle("pre_rst", 32'h500 + 32'(4 * i), 32'h7 + i, 4'hF, 1'b0);
        chk("pre_rst_count3", 32'(count), 32'd3);
        #2;
        reset = 1'b1;
        io_dmem_wen = 4'hF;
        #1;
        exp_q.delete();
        check_outputs("mid_rst");
        chk("mid_rst_valid", 32'(bus_valid), 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        io_dmem_wen = '0;
        @(posedge clock);
        #1;
        cycle("post_rst", 32'h600, 32'hCAFEF00D, 4'hF, 1'b0);
        chk("post_rst_addr", bus_addr, 32'h600);
        chk("post_rst_data", bus_wdata, 32'hCAFEF00D);
        idle("post_rst_d", 1'b1);

        // Random traffic over a small address pool so merges and stalls occur
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra;
            logic [SW-1:0] rw;
            ra = 32'h800 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            rw = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            cycle("rnd", ra, $urandom, rw, 1'($urandom_range(0, 2) == 0));
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            idle("rnd_drain", 1'b1);
            guard++;
        end
        chk("rnd_empty", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_write_buffer.md
DMEM_WRITE_BUFFER -- requirements
Module: dmem_write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered write entries (power of two, at least 2).
REQ-002 The block SHALL have parameter AW, default 32, meaning the address width.
REQ-003 The block SHALL have parameter DW, default 32, meaning the data width (byte-strobe width is DW/8).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port io_dmem_waddr, input, AW bits: core store byte address.
REQ-007 The block SHALL have port io_dmem_wdata, input, DW bits: core store data, lane-aligned.
REQ-008 The block SHALL have port io_dmem_wen, input, DW/8 bits: core store byte strobes; nonzero means a store request.
REQ-009 The block SHALL have port io_stall, output, 1 bit: the store was not accepted and the core holds it.
REQ-010 The block SHALL have port bus_valid, output, 1 bit: the head entry is presented on the bus.
REQ-011 The block SHALL have port bus_ready, input, 1 bit: the memory accepts the head entry.
REQ-012 The block SHALL have port bus_addr, output, AW bits: head entry word address with the low two bits zero.
REQ-013 The block SHALL have port bus_wdata, output, DW bits: head entry data.
REQ-014 The block SHALL have port bus_wstrb, output, DW/8 bits: head entry byte strobes.
REQ-015 The block SHALL have port count, output, log2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-016 A store request SHALL be any cycle with io_dmem_wen != 0; io_dmem_wen == 0 SHALL leave the buffer unchanged apart from dequeue.
REQ-017 io_stall SHALL equal (count == DEPTH) AND (io_dmem_wen != 0), combinationally; a stalled store SHALL NOT be captured, even if dequeue happens in the same cycle.
REQ-018 A non-stalled store SHALL either merge (REQ-019) or enqueue at the tail: addr = {waddr[AW-1:2],2'b00}, data = wdata, strobes = wen, with count incremented.
REQ-019 Merge: when count >= 2 and waddr[AW-1:2] equals the word address of the most recently written entry (the tail-1 entry, which by REQ-020 is not the head), the store SHALL merge into that entry.
REQ-020 During a merge, only data lanes with a set wen bit SHALL be overwritten, stored strobes SHALL be ORed with wen, and count SHALL be unchanged; the head entry SHALL never be modified.
REQ-021 bus_valid SHALL equal (count != 0); bus_addr, bus_wdata and bus_wstrb SHALL present the head entry while bus_valid is high, and SHALL be driven to 0 while count == 0.
REQ-022 Dequeue SHALL occur on a cycle where bus_valid and bus_ready are both high: the head advances and count decrements.
REQ-023 While bus_valid is high and bus_ready is low, the bus outputs SHALL be held stable.
REQ-024 Simultaneous enqueue and dequeue with 0 < count < DEPTH SHALL leave count unchanged.
REQ-025 Simultaneous merge and dequeue SHALL decrement count by 1.
REQ-026 Latency: a store accepted at edge N into an empty buffer SHALL appear with bus_valid high after edge N; there SHALL be no same-cycle pass-through from input to bus.
REQ-027 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-028 Stores SHALL leave the bus in acceptance order, merged stores at their original entry position.
REQ-029 bus_ready while count == 0 SHALL be ignored.

Reset
REQ-030 Asserting reset SHALL immediately, without waiting for a clock, set count = 0 and both pointers = 0, drive bus_valid = 0 and bus_addr/bus_wdata/bus_wstrb = 0, and make io_stall follow REQ-017 with count = 0 (i.e. 0).
REQ-031 Entries in flight when reset is asserted SHALL be discarded, and entry storage SHALL need no reset.
REQ-032 The first store after reset deassertion SHALL be accepted normally.

Verification
REQ-033 Single store: waddr=0x1004, wdata=0xDEADBEEF, wen=0xF, bus_ready=1 -> the next cycle shows bus_valid=1, bus_addr=0x1004, bus_wstrb=0xF, and count returns to 0 one cycle later.
REQ-034 Fill: with bus_ready=0, four stores to 0x0, 0x10, 0x20, 0x30 -> count=4; then a fifth store to 0x40 -> io_stall=1 and count stays at 4; then bus_ready=1 -> 0x0, 0x10, 0x20, 0x30 drain in order.
REQ-035 Merge: with bus_ready=0, store 0x100 with wen=0x1 and data 0xAA, then 0x200 with wen=0x3, then 0x202 with data 0xBBBB0000 and wen=0xC -> count=2, and the second entry is bus_addr=0x200, wstrb=0xF with the upper half equal to 0xBBBB.
REQ-036 No head merge: count=1 holding head 0x300 and bus_ready=0, then store 0x300 -> count=2 with no merge.
REQ-037 Wrap and concurrency: 10 back-to-back stores with bus_ready toggling every cycle -> order preserved, count never exceeds 4, and counts stay correct through pointer wrap.
REQ-038 Reset mid-operation: count=3, then reset asserted between clock edges -> bus_valid=0 and count=0 immediately, and the first store after release appears at the bus head.
